// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the fetch/data memory bus arbiter.
// Contents: grant FSM state encoding, full-word byte select, master indices,
// and the select/timeout counter widths.
package mem_bus_arbiter_pkg;

  localparam int unsigned SEL_W = 4;
  localparam int unsigned TMO_W = 8;

  localparam logic [SEL_W-1:0] SEL_FULL = 4'hF;

  localparam int unsigned MST_IF   = 0;
  localparam int unsigned MST_DATA = 1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GRANT_IF   = 2'd1,
    ST_GRANT_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/mem_bus_arbiter_bus_tmo_cnt.sv
// Bus timeout counter: counts grant cycles without a slave ack.
// Ports: clk, rst (async active-low), clr (reload to zero), inc (count one
// cycle), expire_c (count has reached TIMEOUT-1; combinational from the count).
module mem_bus_arbiter_bus_tmo_cnt
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire_c
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign expire_c = (cnt == TMO_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the instruction-fetch port (m0) and the data port (m1) onto one
// shared single-port memory bus, with data priority, a fetch anti-starvation
// limit and a bus timeout.
// Ports: m0_* fetch req/addr -> rdata/ack/err; m1_* data req/we/addr/sel/wdata
// -> rdata/ack/err; bus_* registered shared bus master side plus slave
// rdata/ack; stall_o = {mem stall, fetch stall}, combinational.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DATA_BURST_MAX = 4,
  parameter int unsigned TIMEOUT        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic [1:0]        stall_o
);

  localparam int unsigned CNT_W = $clog2(DATA_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_BURST_MAX);

  state_t           state;
  logic [CNT_W-1:0] data_cnt;
  logic             in_grant_c;
  logic             tmo_expire_c;
  logic             can_if_c;
  logic             can_data_c;
  logic             pick_if_c;
  logic             pick_data_c;

  // A master whose ack is high this cycle still shows its old req; mask it.
  assign can_if_c   = m0_req_i & ~m0_ack_o;
  assign can_data_c = m1_req_i & ~m1_ack_o;
  assign in_grant_c = (state != ST_IDLE);

  assign stall_o[MST_IF]   = m0_req_i & ~m0_ack_o;
  assign stall_o[MST_DATA] = m1_req_i & ~m1_ack_o;

  // Idle arbitration: data first unless fetch has waited out a full data burst.
  always_comb begin
    pick_if_c   = 1'b0;
    pick_data_c = 1'b0;
    if (state == ST_IDLE) begin
      if (can_if_c && (data_cnt == CNT_MAX)) begin
        pick_if_c = 1'b1;
      end else if (can_data_c) begin
        pick_data_c = 1'b1;
      end else if (can_if_c) begin
        pick_if_c = 1'b1;
      end
    end
  end

  mem_bus_arbiter_bus_tmo_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr      (~in_grant_c),
    .inc      (in_grant_c & ~bus_ack_i),
    .expire_c (tmo_expire_c)
  );

  // Grant FSM with registered bus and completion outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      data_cnt    <= '0;
      m0_rdata_o  <= '0;
      m0_ack_o    <= 1'b0;
      m0_err_o    <= 1'b0;
      m1_rdata_o  <= '0;
      m1_ack_o    <= 1'b0;
      m1_err_o    <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
    end else begin
      m0_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m1_err_o <= 1'b0;

      // Burst length of data grants seen while a fetch is waiting.
      if (!m0_req_i || pick_if_c) begin
        data_cnt <= '0;
      end else if (pick_data_c && (data_cnt != CNT_MAX)) begin
        data_cnt <= data_cnt + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (pick_if_c) begin
            state       <= ST_GRANT_IF;
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= m0_addr_i;
            bus_sel_o   <= SEL_FULL;
            bus_wdata_o <= '0;
          end else if (pick_data_c) begin
            state       <= ST_GRANT_DATA;
            bus_req_o   <= 1'b1;
            bus_we_o    <= m1_we_i;
            bus_addr_o  <= m1_addr_i;
            bus_sel_o   <= m1_sel_i;
            bus_wdata_o <= m1_wdata_i;
          end
        end
        ST_GRANT_IF: begin
          if (bus_ack_i || tmo_expire_c) begin
            state      <= ST_IDLE;
            bus_req_o  <= 1'b0;
            m0_ack_o   <= 1'b1;
            m0_err_o   <= ~bus_ack_i;
            m0_rdata_o <= bus_ack_i ? bus_rdata_i : '0;
          end
        end
        ST_GRANT_DATA: begin
          if (bus_ack_i || tmo_expire_c) begin
            state      <= ST_IDLE;
            bus_req_o  <= 1'b0;
            m1_ack_o   <= 1'b1;
            m1_err_o   <= ~bus_ack_i;
            m1_rdata_o <= bus_ack_i ? bus_rdata_i : '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          bus_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// masters and slave, every cycle compared against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BURST  = 4;
  localparam int unsigned TMO    = 16;

  logic              clk;
  logic              rst;
  logic              m0_req_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_rdata_o;
  logic              m0_ack_o;
  logic              m0_err_o;
  logic              m1_req_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [3:0]        m1_sel_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic [DATA_W-1:0] m1_rdata_o;
  logic              m1_ack_o;
  logic              m1_err_o;
  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [3:0]        bus_sel_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_ack_i;
  logic [1:0]        stall_o;

  mem_bus_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .DATA_BURST_MAX (BURST),
    .TIMEOUT        (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m0_req_i    (m0_req_i),
    .m0_addr_i   (m0_addr_i),
    .m0_rdata_o  (m0_rdata_o),
    .m0_ack_o    (m0_ack_o),
    .m0_err_o    (m0_err_o),
    .m1_req_i    (m1_req_i),
    .m1_we_i     (m1_we_i),
    .m1_addr_i   (m1_addr_i),
    .m1_sel_i    (m1_sel_i),
    .m1_wdata_i  (m1_wdata_i),
    .m1_rdata_o  (m1_rdata_o),
    .m1_ack_o    (m1_ack_o),
    .m1_err_o    (m1_err_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_sel_o   (bus_sel_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i),
    .stall_o     (stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (-1 none), how long it has waited,
  // data grants made while fetch waits, and what each master last saw.
  int          mdl_own;
  int          mdl_wait;
  int          mdl_run;
  bit          mdl_ack [2];
  bit          mdl_err [2];
  logic [31:0] mdl_rd  [2];
  bit          mdl_breq;
  bit          mdl_bwe;
  logic [31:0] mdl_baddr;
  logic [31:0] mdl_bwd;
  logic [3:0]  mdl_bsel;

  task automatic model_reset();
    mdl_own   = -1;
    mdl_wait  = 0;
    mdl_run   = 0;
    mdl_ack   = '{0, 0};
    mdl_err   = '{0, 0};
    mdl_rd    = '{32'h0, 32'h0};
    mdl_breq  = 0;
    mdl_bwe   = 0;
    mdl_baddr = '0;
    mdl_bwd   = '0;
    mdl_bsel  = '0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic step();
    int          win;
    bit          c0;
    bit          c1;
    int          n_own;
    int          n_wait;
    int          n_run;
    bit          n_ack [2];
    bit          n_err [2];
    logic [31:0] n_rd  [2];
    bit          n_breq;
    bit          n_bwe;
    logic [31:0] n_baddr;
    logic [31:0] n_bwd;
    logic [3:0]  n_bsel;
    win = -1;
    n_own = mdl_own; n_wait = mdl_wait; n_run = mdl_run;
    n_ack = '{0, 0}; n_err = '{0, 0}; n_rd = mdl_rd;
    n_breq = mdl_breq; n_bwe = mdl_bwe; n_baddr = mdl_baddr; n_bwd = mdl_bwd; n_bsel = mdl_bsel;
    if (mdl_own < 0) begin
      c0 = m0_req_i && !mdl_ack[0];
      c1 = m1_req_i && !mdl_ack[1];
      if (c0 && mdl_run == BURST) win = 0;
      else if (c1) win = 1;
      else if (c0) win = 0;
      if (win == 0) begin
        n_own = 0; n_wait = 0; n_breq = 1; n_bwe = 0;
        n_baddr = m0_addr_i; n_bsel = 4'hF; n_bwd = '0;
      end else if (win == 1) begin
        n_own = 1; n_wait = 0; n_breq = 1; n_bwe = m1_we_i;
        n_baddr = m1_addr_i; n_bsel = m1_sel_i; n_bwd = m1_wdata_i;
      end
    end else if (bus_ack_i || mdl_wait == TMO - 1) begin
      n_ack[mdl_own] = 1;
      n_err[mdl_own] = !bus_ack_i;
      n_rd[mdl_own]  = bus_ack_i ? bus_rdata_i : 32'h0;
      n_own = -1; n_breq = 0;
    end else begin
      n_wait = mdl_wait + 1;
    end
    if (!m0_req_i || win == 0) n_run = 0;
    else if (win == 1 && mdl_run < BURST) n_run = mdl_run + 1;
    @(posedge clk);
    mdl_own = n_own; mdl_wait = n_wait; mdl_run = n_run;
    mdl_ack = n_ack; mdl_err = n_err; mdl_rd = n_rd;
    mdl_breq = n_breq; mdl_bwe = n_bwe; mdl_baddr = n_baddr; mdl_bwd = n_bwd; mdl_bsel = n_bsel;
    #1;
  endtask

  task automatic check_outputs();
    check_val("bus_req", bus_req_o, mdl_breq);
    if (mdl_breq) begin
      check_val("bus_we", bus_we_o, mdl_bwe);
      check_val("bus_addr", bus_addr_o, mdl_baddr);
      check_val("bus_sel", bus_sel_o, mdl_bsel);
      check_val("bus_wdata", bus_wdata_o, mdl_bwd);
    end
    check_val("m0_ack", m0_ack_o, mdl_ack[0]);
    check_val("m1_ack", m1_ack_o, mdl_ack[1]);
    if (mdl_ack[0]) check_val("m0_err", m0_err_o, mdl_err[0]);
    if (mdl_ack[1]) check_val("m1_err", m1_err_o, mdl_err[1]);
    check_val("m0_rdata", m0_rdata_o, mdl_rd[0]);
    check_val("m1_rdata", m1_rdata_o, mdl_rd[1]);
    check_val("stall", stall_o, {m1_req_i & ~mdl_ack[1], m0_req_i & ~mdl_ack[0]});
  endtask

  // Called just after an edge with inputs set; compares then clocks once.
  task automatic cycle();
    #1;
    check_outputs();
    step();
  endtask

  task automatic drain(input int n);
    m0_req_i = 0;
    m1_req_i = 0;
    repeat (n) begin
      bus_ack_i = mdl_breq;
      cycle();
    end
    bus_ack_i = 0;
  endtask

  task automatic new_fields(input int m);
    if (m == 0) begin
      m0_addr_i = $urandom;
    end else begin
      m1_we_i    = 1'($urandom_range(0, 1));
      m1_addr_i  = $urandom;
      m1_sel_i   = 4'($urandom_range(0, 15));
      m1_wdata_i = $urandom;
    end
  endtask

  bit prev_ack [2];

  initial begin
    rst = 1'b0;
    m0_req_i = 0; m0_addr_i = '0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_sel_i = '0; m1_wdata_i = '0;
    bus_rdata_i = '0; bus_ack_i = 0;
    model_reset();

    // Reset state
    #1;
    check_val("rst_bus_req", bus_req_o, 0);
    check_val("rst_m0_ack", m0_ack_o, 0);
    check_val("rst_m1_ack", m1_ack_o, 0);
    check_val("rst_bus_addr", bus_addr_o, 0);
    check_val("rst_m1_rdata", m1_rdata_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single fetch, slave acks two cycles after bus_req_o rises
    m0_req_i = 1; m0_addr_i = 32'h0000_0004;
    cycle();
    check_val("t1_bus_req", bus_req_o, 1);
    check_val("t1_bus_we", bus_we_o, 0);
    check_val("t1_bus_sel", bus_sel_o, 4'hF);
    check_val("t1_bus_addr", bus_addr_o, 32'h4);
    cycle();
    check_val("t1_stall_wait", stall_o[0], 1);
    bus_ack_i = 1; bus_rdata_i = 32'h3401_0001;
    cycle();
    bus_ack_i = 0; bus_rdata_i = '0;
    check_val("t1_m0_ack", m0_ack_o, 1);
    check_val("t1_m0_rdata", m0_rdata_o, 32'h3401_0001);
    check_val("t1_m0_err", m0_err_o, 0);
    check_val("t1_stall_done", stall_o[0], 0);
    cycle();
    check_val("t1_no_regrant", bus_req_o, 0);
    check_val("t1_ack_one_cycle", m0_ack_o, 0);
    m0_req_i = 0;
    cycle();

    // Simultaneous requests: data first, fetch right after the data ack
    m0_req_i = 1; m0_addr_i = 32'h0000_0008;
    m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h0000_0200; m1_sel_i = 4'hF; m1_wdata_i = '0;
    cycle();
    check_val("t2_data_first", bus_addr_o, 32'h200);
    bus_ack_i = 1; bus_rdata_i = 32'h1111_2222;
    cycle();
    bus_ack_i = 0;
    check_val("t2_m1_ack", m1_ack_o, 1);
    check_val("t2_gap", bus_req_o, 0);
    cycle();
    m1_req_i = 0;
    check_val("t2_fetch_req", bus_req_o, 1);
    check_val("t2_fetch_addr", bus_addr_o, 32'h8);
    bus_ack_i = 1; bus_rdata_i = 32'h3333_4444;
    cycle();
    bus_ack_i = 0;
    check_val("t2_m0_rdata", m0_rdata_o, 32'h3333_4444);
    cycle();
    m0_req_i = 0;
    cycle();

    // Both masters held high, slave acks immediately
    m0_req_i = 1; m0_addr_i = 32'h0000_0010;
    m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h0000_0400; m1_sel_i = 4'hF;
    repeat (24) begin
      bus_ack_i = mdl_breq;
      bus_rdata_i = $urandom;
      cycle();
    end
    drain(4);
    cycle();

    // Data read timeout, then a late ack in idle
    m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h0000_0300; m1_sel_i = 4'hF;
    cycle();
    repeat (15) cycle();
    check_val("t4_still_granted", bus_req_o, 1);
    cycle();
    check_val("t4_bus_req_drop", bus_req_o, 0);
    check_val("t4_m1_ack", m1_ack_o, 1);
    check_val("t4_m1_err", m1_err_o, 1);
    check_val("t4_m1_rdata", m1_rdata_o, 0);
    cycle();
    m1_req_i = 0;
    bus_ack_i = 1; bus_rdata_i = 32'hBAD0_BAD0;
    cycle();
    bus_ack_i = 0;
    check_val("t4_late_ack_m1", m1_ack_o, 0);
    check_val("t4_late_ack_m0", m0_ack_o, 0);
    check_val("t4_late_rdata", m1_rdata_o, 0);
    cycle();

    // Partial write
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h0000_0100; m1_sel_i = 4'b0011; m1_wdata_i = 32'hDEAD_BEEF;
    cycle();
    check_val("t5_we", bus_we_o, 1);
    check_val("t5_addr", bus_addr_o, 32'h100);
    check_val("t5_sel", bus_sel_o, 4'b0011);
    check_val("t5_wdata", bus_wdata_o, 32'hDEAD_BEEF);
    bus_ack_i = 1; bus_rdata_i = 32'h0000_CAFE;
    cycle();
    bus_ack_i = 0;
    check_val("t5_m1_ack", m1_ack_o, 1);
    check_val("t5_m1_err", m1_err_o, 0);
    check_val("t5_m1_rdata", m1_rdata_o, 32'h0000_CAFE);
    cycle();
    m1_req_i = 0; m1_we_i = 0;
    cycle();

    // Asynchronous reset in the middle of a grant
    m0_req_i = 1; m0_addr_i = 32'h0000_0040;
    cycle();
    cycle();
    #2;
    rst = 1'b0;
    #1;
    check_val("t6_bus_req", bus_req_o, 0);
    check_val("t6_m0_ack", m0_ack_o, 0);
    check_val("t6_m1_ack", m1_ack_o, 0);
    check_val("t6_bus_addr", bus_addr_o, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle();
    check_val("t6_regrant", bus_req_o, 1);
    check_val("t6_regrant_addr", bus_addr_o, 32'h40);
    bus_ack_i = 1; bus_rdata_i = 32'h0000_0013;
    cycle();
    bus_ack_i = 0;
    check_val("t6_m0_ack_after", m0_ack_o, 1);
    check_val("t6_m0_rdata_after", m0_rdata_o, 32'h13);
    cycle();
    m0_req_i = 0;
    cycle();

    // Randomized traffic: responsive slave first, then a mostly silent one
    prev_ack = '{0, 0};
    for (int i = 0; i < 3000; i++) begin
      int pct;
      pct = (i < 1500) ? 50 : 6;
      for (int m = 0; m < 2; m++) begin
        bit r;
        r = (m == 0) ? m0_req_i : m1_req_i;
        if (prev_ack[m]) begin
          r = ($urandom_range(0, 1) == 1);
          new_fields(m);
        end else if (!r && mdl_own != m) begin
          if ($urandom_range(0, 99) < 30) begin
            r = 1;
            new_fields(m);
          end
        end else if (r && mdl_own == m && $urandom_range(0, 99) < 3) begin
          r = 0;
        end
        if (m == 0) m0_req_i = r;
        else m1_req_i = r;
        prev_ack[m] = mdl_ack[m];
      end
      if (mdl_breq) bus_ack_i = ($urandom_range(0, 99) < pct);
      else bus_ack_i = ($urandom_range(0, 99) < 4);
      bus_rdata_i = $urandom;
      cycle();
    end
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Arbitrates the instruction-fetch port (master 0, fed by pc_reg) and the data port (master 1, fed by the mem stage) onto one shared single-port memory bus. It runs a grant FSM with per-master req/ack handshakes, a data-priority policy with a fetch anti-starvation limit, and a bus timeout. It sits between the pipeline core and the memory slave. It also emits the stall requests the pipeline controller uses to freeze stages while an access is pending.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
DATA_BURST_MAX, 4, maximum consecutive data grants while a fetch is waiting
TIMEOUT, 16, grant cycles without bus_ack_i before the access is aborted (2..255)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
m0_req_i  in  1  fetch request, held until m0_ack_o
m0_addr_i  in  ADDR_W  fetch address
m0_rdata_o  out  DATA_W  fetched instruction, valid while m0_ack_o
m0_ack_o  out  1  one-cycle completion pulse
m0_err_o  out  1  completion was a timeout; qualifies m0_ack_o
m1_req_i  in  1  data request, held until m1_ack_o
m1_we_i  in  1  1 = write
m1_addr_i  in  ADDR_W  data address
m1_sel_i  in  4  byte enables
m1_wdata_i  in  DATA_W  write data
m1_rdata_o  out  DATA_W  read data, valid while m1_ack_o
m1_ack_o  out  1  one-cycle completion pulse
m1_err_o  out  1  timeout flag; qualifies m1_ack_o
bus_req_o  out  1  shared bus request
bus_we_o  out  1  shared bus write enable
bus_addr_o  out  ADDR_W  shared bus address
bus_sel_o  out  4  shared bus byte enables
bus_wdata_o  out  DATA_W  shared bus write data
bus_rdata_i  in  DATA_W  slave read data
bus_ack_i  in  1  slave completion, one cycle
stall_o  out  2  bit0 = fetch stall, bit1 = mem stall

Behaviour:
- Reset (rst=0) takes effect immediately, mid-transfer included. State = IDLE. Every output, data_cnt and tmo_cnt = 0.
- FSM states: IDLE, GRANT_IF, GRANT_DATA.
- IDLE arbitration:
  - A master is masked if its ack_o is high this cycle, so a stale req is not re-granted.
  - Fetch wins if m0 is unmasked and requesting and data_cnt == DATA_BURST_MAX.
  - Otherwise data wins if m1 is unmasked and requesting.
  - Otherwise fetch wins if m0 is unmasked and requesting.
  - Otherwise stay in IDLE.
- On grant, register the bus outputs. bus_req_o rises the cycle after the decision, giving 1-cycle arbitration latency.
  - Fetch grant drives we=0, sel=4'hF, wdata=0.
- GRANT_x: bus_* hold stable regardless of requester inputs. tmo_cnt increments each cycle without an ack.
- bus_ack_i in GRANT_x:
  - Next cycle: bus_req_o=0, state=IDLE, rdata_o=bus_rdata_i captured, ack_o=1 for one cycle, err_o=0.
  - For writes, rdata_o = bus_rdata_i unchanged.
  - Minimum back-to-back transfer period is 3 cycles.
- Timeout: when tmo_cnt reaches TIMEOUT-1 and bus_ack_i is still 0:
  - Next cycle: bus_req_o=0, state=IDLE, ack_o=1, err_o=1, rdata_o=0.
  - A late bus_ack_i arriving in IDLE is ignored.
- bus_ack_i in IDLE is always ignored.
- A requester that drops req mid-grant does not abort the transfer; ack_o still pulses.
- data_cnt:
  - Increments (saturating at DATA_BURST_MAX) on each data grant made while m0_req_i=1.
  - Clears on a fetch grant, or in any cycle with m0_req_i=0.
- stall_o[0] = m0_req_i & ~m0_ack_o; stall_o[1] = m1_req_i & ~m1_ack_o. Both are combinational.
- ack_o and err_o are registered. rdata_o holds its value until the next completion of the same master.

Decomposition:
- Shared package: FSM state encodings, the 4'hF full-word select constant, and master index constants (MST_IF=0, MST_DATA=1).
- One natural sub-module: bus_tmo_cnt, an 8-bit counter with clear and expire output, parameterised by TIMEOUT.

Test Plan:
- Fetch, addr 0x00000004; slave acks 2 cycles after bus_req_o with 0x34010001 -> bus_we_o=0, bus_sel_o=4'hF; m0_ack_o pulses one cycle after bus_ack_i with m0_rdata_o=0x34010001, m0_err_o=0; stall_o[0] high until then.
- m0 and m1 requests rise in the same IDLE cycle -> data is granted first and fetch after m1_ack_o; bus_req_o low for 1 cycle between the two grants.
- m1_req_i held high continuously with m0 pending, DATA_BURST_MAX=4, slave acks immediately -> exactly 4 data grants, then 1 fetch grant, then data resumes.
- TIMEOUT=16, slave never acks a data read -> bus_req_o drops after 16 grant cycles; m1_ack_o=1, m1_err_o=1, m1_rdata_o=0; an ack injected 2 cycles later is ignored.
- Write, addr 0x00000100, sel 4'b0011, wdata 0xDEADBEEF -> bus_* match the request; m1_ack_o pulses with m1_err_o=0.
- Assert rst low mid-grant -> bus_req_o and all acks are 0 with no clock edge; after release, a new fetch completes normally.
